iram_dump_tx: RTL and testbench

Readback transmitter for the instruction-memory loader: dumps a block of 16-bit IRAM words back out over the UART transmit path. Each word is sent as two bytes, MSB first, the same order the loader assembles them on receive. The dump ends with one XOR checksum byte so the host can verify a program image after upload. The block sits between the micro's IRAM read port and the uart `wr_uart`/`w_data`/`tx_full` transmit FIFO interface, and runs in the uart clock domain.

---
 rtl/iram_dump_tx.sv | 129 ++++++++++++
 tb/tb_iram_dump_tx.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_dump_tx.sv
// IRAM readback transmitter: streams a block of 16-bit IRAM words to the uart TX FIFO,
// MSB byte first, and closes the dump with an XOR checksum of every data byte.
module iram_dump_tx #(
    parameter int WIDTH          = 16,
    parameter int IRAM_ADDR_BITS = 8,
    parameter int WORD_COUNT     = 26
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [IRAM_ADDR_BITS-1:0] start_addr,
    output logic [IRAM_ADDR_BITS-1:0] mem_addr,
    input  logic [WIDTH-1:0]          mem_data,
    input  logic                      tx_full,
    output logic                      wr_uart,
    output logic [7:0]                w_data,
    output logic                      busy,
    output logic                      done
);

    localparam int CNT_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORD_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND_HI,
        SEND_LO,
        SEND_CSUM,
        DONE
    } state_e;

    state_e                    state_q;
    logic [IRAM_ADDR_BITS-1:0] addr_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [WIDTH-1:0]          word_q;
    logic [7:0]                csum_q;
    logic [7:0]                csum_d;
    logic [7:0]                send_byte;
    logic                      busy_q;
    logic                      done_q;
    logic                      tx_fire;

    // Byte presented to the FIFO in each send state.
    always_comb begin
        send_byte = 8'h00;
        case (state_q)
            SEND_HI:   send_byte = word_q[15:8];
            SEND_LO:   send_byte = word_q[7:0];
            SEND_CSUM: send_byte = csum_q;
            default:   send_byte = 8'h00;
        endcase
    end

    // NOTE: the strobe is qualified with reset so no byte escapes in the cycle reset is applied.
    assign tx_fire = (state_q inside {SEND_HI, SEND_LO, SEND_CSUM}) && !tx_full && reset;
    assign csum_d  = csum_q ^ send_byte;

    assign wr_uart  = tx_fire;
    assign w_data   = tx_fire ? send_byte : 8'h00;
    assign mem_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q  <= start_addr;
                        cnt_q   <= '0;
                        csum_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= READ;
                    end
                end
                READ: begin
                    state_q <= LATCH;
                end
                LATCH: begin
                    word_q  <= mem_data;
                    state_q <= SEND_HI;
                end
                SEND_HI: begin
                    if (!tx_full) begin
                        csum_q  <= csum_d;
                        state_q <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (!tx_full) begin
                        csum_q <= csum_d;
                        if (cnt_q == LAST_WORD) begin
                            state_q <= SEND_CSUM;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                            addr_q  <= addr_q + IRAM_ADDR_BITS'(1);
                            state_q <= READ;
                        end
                    end
                end
                SEND_CSUM: begin
                    if (!tx_full) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iram_dump_tx.sv
// Scoreboard bench for iram_dump_tx: three instances (26-word, 4-word, 1-word dumps)
// share one IRAM model; a negedge monitor pops expected bytes and addresses as the DUTs emit them.
module tb_iram_dump_tx;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tx_full = 1'b0;
    logic [7:0]  start_addr = 8'h00;
    logic [NI-1:0] start_v = '0;

    logic [7:0]  ma_a, ma_b, ma_c;
    logic [15:0] md_a, md_b, md_c;
    logic        wr_a, wr_b, wr_c;
    logic [7:0]  wd_a, wd_b, wd_c;
    logic        bz_a, bz_b, bz_c;
    logic        dn_a, dn_b, dn_c;

    logic [NI-1:0]      wr_v, bz_v, dn_v;
    logic [NI-1:0][7:0] wd_v, ma_v;
    assign wr_v = {wr_c, wr_b, wr_a};
    assign bz_v = {bz_c, bz_b, bz_a};
    assign dn_v = {dn_c, dn_b, dn_a};
    assign wd_v = {wd_c, wd_b, wd_a};
    assign ma_v = {ma_c, ma_b, ma_a};

    logic [15:0] mem [256];
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_addr_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;
    int first_wr = -1;
    int done_cyc[NI] = '{default: 0};
    int done_cnt[NI] = '{default: 0};
    int st_lo1 = -1, st_hi1 = -1, st_lo2 = -1, st_hi2 = -1;
    logic       b_busy_prev = 1'b0;
    logic [7:0] b_addr_prev = 8'h00;

    iram_dump_tx #(.WIDTH(16), .IRAM_ADDR_BITS(8), .WORD_COUNT(26)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .start_addr(start_addr),
        .mem_addr(ma_a), .mem_data(md_a), .tx_full(tx_full),
        .wr_uart(wr_a), .w_data(wd_a), .busy(bz_a), .done(dn_a)
    );

    iram_dump_tx #(.WIDTH(16), .IRAM_ADDR_BITS(8), .WORD_COUNT(4)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .start_addr(start_addr),
        .mem_addr(ma_b), .mem_data(md_b), .tx_full(tx_full),
        .wr_uart(wr_b), .w_data(wd_b), .busy(bz_b), .done(dn_b)
    );

    iram_dump_tx #(.WIDTH(16), .IRAM_ADDR_BITS(8), .WORD_COUNT(1)) u_dut_c (
        .clk(clk), .reset(reset), .start(start_v[2]), .start_addr(start_addr),
        .mem_addr(ma_c), .mem_data(md_c), .tx_full(tx_full),
        .wr_uart(wr_c), .w_data(wd_c), .busy(bz_c), .done(dn_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read IRAM ports, one per instance.
    always @(posedge clk) begin
        md_a <= mem[ma_a];
        md_b <= mem[ma_b];
        md_c <= mem[ma_c];
    end

    // Output monitor: pops the scoreboard on every write strobe.
    always @(negedge clk) begin : mon
        logic [7:0] e;
        for (int i = 0; i < NI; i++) begin
            if (wr_v[i]) begin
                checks++;
                if (tx_full) begin
                    errors++;
                    $display("FAIL write_while_full inst=%0d cyc=%0d", i, cyc);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte inst=%0d got=%02h expected=none", i, wd_v[i]);
                end else begin
                    e = exp_q.pop_front();
                    if (wd_v[i] !== e) begin
                        errors++;
                        $display("FAIL byte inst=%0d cyc=%0d got=%02h expected=%02h", i, cyc, wd_v[i], e);
                    end
                end
                if (first_wr < 0) first_wr = cyc;
            end else begin
                checks++;
                if (wd_v[i] !== 8'h00) begin
                    errors++;
                    $display("FAIL w_data_idle inst=%0d got=%02h expected=00", i, wd_v[i]);
                end
            end
            if (dn_v[i]) begin
                checks++;
                if (wr_v[i]) begin
                    errors++;
                    $display("FAIL done_with_write inst=%0d got=1 expected=0", i);
                end
                done_cyc[i] = cyc;
                done_cnt[i]++;
            end
        end
        if (bz_b && (!b_busy_prev || ma_b != b_addr_prev)) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL addr_trace got=%02h expected=none", ma_b);
            end else begin
                e = exp_addr_q.pop_front();
                if (ma_b !== e) begin
                    errors++;
                    $display("FAIL addr_trace got=%02h expected=%02h", ma_b, e);
                end
            end
        end
        b_busy_prev = bz_b;
        b_addr_prev = ma_b;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic stall(input int k);
        return (k >= st_lo1 && k <= st_hi1) || (k >= st_lo2 && k <= st_hi2);
    endfunction

    task automatic push_dump(input logic [7:0] sa, input int wc);
        logic [7:0]  a;
        logic [7:0]  cs;
        logic [15:0] w;
        a  = sa;
        cs = 8'h00;
        for (int i = 0; i < wc; i++) begin
            w = mem[a];
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
            cs = cs ^ w[15:8] ^ w[7:0];
            a  = a + 8'd1;
        end
        exp_q.push_back(cs);
    endtask

    task automatic launch(input int inst, input logic [7:0] sa, input logic hold);
        start_addr    = sa;
        start_v[inst] = 1'b1;
        t0            = cyc;
        first_wr      = -1;
        tx_full       = stall(0);
        step();
        tx_full = stall(cyc - t0);
        if (!hold) start_v[inst] = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int limit, output int delay);
        int n0;
        n0    = done_cnt[inst];
        delay = -1;
        for (int k = 0; k < limit; k++) begin
            step();
            tx_full = stall(cyc - t0);
            if (done_cnt[inst] != n0) begin
                delay = done_cyc[inst] - t0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        start_v = '0;
        tx_full = 1'b0;
        repeat (3) step();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({wr_v[i], bz_v[i], dn_v[i]} !== 3'b000) begin
                errors++;
                $display("FAIL reset_ctrl inst=%0d got=%b expected=000", i, {wr_v[i], bz_v[i], dn_v[i]});
            end
            checks++;
            if (ma_v[i] !== 8'h00 || wd_v[i] !== 8'h00) begin
                errors++;
                $display("FAIL reset_data inst=%0d got=%02h/%02h expected=00/00", i, ma_v[i], wd_v[i]);
            end
        end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int d;
        for (int i = 0; i < 26; i++) mem[i] = 16'h0100 + 16'(i);
        push_dump(8'h00, 26);
        launch(0, 8'h00, 1'b0);
        wait_done(0, 400, d);
        checks++;
        if (d !== 106) begin errors++; $display("FAIL basic_done_cycle got=%0d expected=106", d); end
        checks++;
        if (first_wr - t0 !== 3) begin errors++; $display("FAIL first_write got=%0d expected=3", first_wr - t0); end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL basic_bytes_left got=%0d expected=0", exp_q.size()); end
        checks++;
        if (bz_v[0] !== 1'b0) begin errors++; $display("FAIL busy_after_done got=%b expected=0", bz_v[0]); end
        repeat (2) step();
    endtask

    task automatic test_back_pressure();
        int d;
        st_lo1 = 3;  st_hi1 = 10;
        st_lo2 = 32; st_hi2 = 34;
        push_dump(8'h00, 26);
        launch(0, 8'h00, 1'b0);
        wait_done(0, 400, d);
        st_lo1 = -1; st_hi1 = -1; st_lo2 = -1; st_hi2 = -1;
        tx_full = 1'b0;
        checks++;
        if (d !== 117) begin errors++; $display("FAIL bp_done_cycle got=%0d expected=117", d); end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_bytes_left got=%0d expected=0", exp_q.size()); end
        repeat (2) step();
    endtask

    task automatic test_start_busy();
        int d;
        int n;
        push_dump(8'h00, 26);
        push_dump(8'h00, 26);
        launch(0, 8'h00, 1'b1);
        wait_done(0, 400, d);
        checks++;
        if (d !== 106) begin errors++; $display("FAIL hold_first_done got=%0d expected=106", d); end
        checks++;
        if (bz_v[0] !== 1'b0) begin errors++; $display("FAIL hold_idle_gap got=%b expected=0", bz_v[0]); end
        step();
        checks++;
        if (bz_v[0] !== 1'b1) begin errors++; $display("FAIL hold_restart got=%b expected=1", bz_v[0]); end
        start_v[0] = 1'b0;
        wait_done(0, 400, d);
        checks++;
        if (d !== 213) begin errors++; $display("FAIL hold_second_done got=%0d expected=213", d); end
        n = done_cnt[0];
        repeat (5) step();
        checks++;
        if (bz_v[0] !== 1'b0 || done_cnt[0] !== n) begin
            errors++;
            $display("FAIL hold_no_third got=%b/%0d expected=0/%0d", bz_v[0], done_cnt[0], n);
        end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL hold_bytes_left got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int d;
        push_dump(8'h00, 26);
        launch(0, 8'h00, 1'b0);
        repeat (15) step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_v[0] !== 1'b0) begin errors++; $display("FAIL partial_write got=%b expected=0", wr_v[0]); end
        step();
        checks++;
        if ({bz_v[0], wr_v[0], dn_v[0]} !== 3'b000 || ma_v[0] !== 8'h00 || wd_v[0] !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_state got=%b addr=%02h data=%02h expected=000 addr=00 data=00",
                     {bz_v[0], wr_v[0], dn_v[0]}, ma_v[0], wd_v[0]);
        end
        checks++;
        if (exp_q.size() !== 46) begin errors++; $display("FAIL reset_mid_bytes got=%0d expected=46", exp_q.size()); end
        exp_q.delete();
        reset = 1'b1;
        step();
        push_dump(8'h00, 26);
        launch(0, 8'h00, 1'b0);
        wait_done(0, 400, d);
        checks++;
        if (d !== 106) begin errors++; $display("FAIL post_reset_done got=%0d expected=106", d); end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL post_reset_bytes got=%0d expected=0", exp_q.size()); end
        repeat (2) step();
    endtask

    task automatic test_wrap();
        int d;
        mem[8'hFE] = 16'($urandom);
        mem[8'hFF] = 16'($urandom);
        mem[8'h00] = 16'($urandom);
        mem[8'h01] = 16'($urandom);
        exp_addr_q.push_back(8'hFE);
        exp_addr_q.push_back(8'hFF);
        exp_addr_q.push_back(8'h00);
        exp_addr_q.push_back(8'h01);
        push_dump(8'hFE, 4);
        launch(1, 8'hFE, 1'b0);
        wait_done(1, 100, d);
        checks++;
        if (d !== 18) begin errors++; $display("FAIL wrap_done got=%0d expected=18", d); end
        checks++;
        if (exp_addr_q.size() !== 0) begin errors++; $display("FAIL wrap_addrs_left got=%0d expected=0", exp_addr_q.size()); end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL wrap_bytes_left got=%0d expected=0", exp_q.size()); end
        repeat (2) step();
    endtask

    task automatic test_single_word();
        int d;
        mem[0] = 16'hA55A;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hFF);
        launch(2, 8'h00, 1'b0);
        wait_done(2, 50, d);
        checks++;
        if (d !== 6) begin errors++; $display("FAIL single_done got=%0d expected=6", d); end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL single_bytes_left got=%0d expected=0", exp_q.size()); end
        repeat (2) step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        foreach (mem[i]) mem[i] = 16'h0000;
        test_reset();
        test_basic();
        test_back_pressure();
        test_start_busy();
        test_reset_mid();
        test_wrap();
        test_single_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
